// File: rtl/game_pkg.sv
// Shared definitions for the jump-the-obstacle game: the control FSM state
// encoding, the player jump states and the default screen/geometry values.
package game_pkg;

    // Control FSM state, shared with the game control FSM (4-7 decode as idle).
    typedef enum logic [2:0] {
        GS_IDLE = 3'd0,
        GS_MENU = 3'd1,
        GS_RUN  = 3'd2,
        GS_OVER = 3'd3
    } game_state_t;

    // Vertical motion of the player.
    typedef enum logic [1:0] {
        JS_GROUND = 2'd0,
        JS_RISE   = 2'd1,
        JS_FALL   = 2'd2
    } jump_state_t;

    // Screen coordinates are 10 bits wide.
    localparam int POS_W = 10;

    // Default geometry and pacing.
    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_GROUND_Y   = 400;
    localparam int DEF_PLAYER_X   = 80;
    localparam int DEF_PLAYER_W   = 32;
    localparam int DEF_OBST_H     = 32;
    localparam int DEF_JUMP_H     = 96;
    localparam int DEF_JUMP_STEP  = 8;
    localparam int DEF_INIT_SPEED = 4;
    localparam int DEF_MAX_SPEED  = 12;
    localparam int DEF_SPEED_UP   = 5;
    localparam int DEF_SCORE_W    = 8;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by a
// rising-edge detector. Produces a one-clock pulse per press; reusable for
// any front-panel button (jump, start).
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize the raw button and keep the previous synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/game_engine.sv
// Game-play datapath: advances the player jump and the obstacle once per
// frame while the control FSM is in rungame, keeps score and raises the
// registered game-over flag GO on a collision.
// Optional build macro HISCORE_EN adds a hiScore output that captures the
// best score at each game over and survives returns to the menu.
module game_engine
    import game_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int GROUND_Y   = DEF_GROUND_Y,
    parameter int PLAYER_X   = DEF_PLAYER_X,
    parameter int PLAYER_W   = DEF_PLAYER_W,
    parameter int OBST_H     = DEF_OBST_H,
    parameter int JUMP_H     = DEF_JUMP_H,
    parameter int JUMP_STEP  = DEF_JUMP_STEP,
    parameter int INIT_SPEED = DEF_INIT_SPEED,
    parameter int MAX_SPEED  = DEF_MAX_SPEED,
    parameter int SPEED_UP   = DEF_SPEED_UP,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         gameState,
    input  logic               frameTick,
    input  logic               jumpButton,
    output logic               GO,
    output logic [SCORE_W-1:0] score,
    output logic [POS_W-1:0]   playerY,
    output logic [POS_W-1:0]   obstacleX
`ifdef HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiScore
`endif
);

    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam int CLR_W   = $clog2(SPEED_UP + 1);

    localparam logic [POS_W-1:0]   RESPAWN_X  = POS_W'(SCREEN_W - 1);
    localparam logic [POS_W-1:0]   GROUND_C   = POS_W'(GROUND_Y);
    localparam logic [POS_W-1:0]   APEX_Y     = POS_W'(GROUND_Y - JUMP_H);
    localparam logic [POS_W-1:0]   HIT_Y      = POS_W'(GROUND_Y - OBST_H);
    localparam logic [POS_W-1:0]   HIT_X_LO   = POS_W'(PLAYER_X);
    localparam logic [POS_W-1:0]   HIT_X_HI   = POS_W'(PLAYER_X + PLAYER_W);
    localparam logic [POS_W-1:0]   STEP_C     = POS_W'(JUMP_STEP);
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(INIT_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
    localparam logic [CLR_W-1:0]   CLR_LIMIT  = CLR_W'(SPEED_UP);

    jump_state_t        jump_q, jump_d;
    logic [POS_W-1:0]   player_y_q, player_y_d;
    logic [POS_W-1:0]   obst_x_q, obst_x_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [CLR_W-1:0]   clr_q, clr_d, clr_inc;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               go_q, go_d;
    logic               jump_req_q, jump_req_d;

    logic               st_menu, st_run, st_over;
    logic               jump_rise;
    logic               frame_adv;
    logic               collision;
    logic [POS_W-1:0]   y_up, y_down;
    logic [POS_W-1:0]   speed_ext;

    btn_sync_edge u_jump_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (jumpButton),
        .rise_o (jump_rise)
    );

    // Decode the control FSM state; unused encodings behave as idle.
    always_comb begin
        st_menu = 1'b0;
        st_run  = 1'b0;
        st_over = 1'b0;
        case (gameState)
            GS_MENU: st_menu = 1'b1;
            GS_RUN:  st_run  = 1'b1;
            GS_OVER: st_over = 1'b1;
            default: ;
        endcase
    end

    // Positions only move on a frame tick of a game that is still alive.
    assign frame_adv = st_run & ~go_q & frameTick;
    assign y_up      = player_y_q - STEP_C;
    assign y_down    = player_y_q + STEP_C;
    assign speed_ext = {{(POS_W - SPEED_W){1'b0}}, speed_q};
    assign collision = (obst_x_q >= HIT_X_LO) && (obst_x_q < HIT_X_HI) &&
                       (player_y_q > HIT_Y);

    // Jump FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_q <= JS_GROUND;
        end else begin
            jump_q <= jump_d;
        end
    end

    // Jump FSM next state: a latched request launches, apex and ground turn it.
    always_comb begin
        jump_d = jump_q;
        if (st_menu) begin
            jump_d = JS_GROUND;
        end else if (frame_adv) begin
            case (jump_q)
                JS_GROUND: if (jump_req_q)         jump_d = JS_RISE;
                JS_RISE:   if (y_up <= APEX_Y)     jump_d = JS_FALL;
                JS_FALL:   if (y_down >= GROUND_C) jump_d = JS_GROUND;
                default:                           jump_d = JS_GROUND;
            endcase
        end
    end

    // Frame update of player height, obstacle, score and speed ramp.
    always_comb begin
        player_y_d = player_y_q;
        obst_x_d   = obst_x_q;
        speed_d    = speed_q;
        clr_d      = clr_q;
        score_d    = score_q;
        clr_inc    = clr_q + 1'b1;
        if (st_menu) begin
            player_y_d = GROUND_C;
            obst_x_d   = RESPAWN_X;
            speed_d    = SPEED_INIT;
            clr_d      = '0;
            score_d    = '0;
        end else if (frame_adv) begin
            case (jump_q)
                JS_RISE: player_y_d = (y_up <= APEX_Y) ? APEX_Y : y_up;
                JS_FALL: player_y_d = (y_down >= GROUND_C) ? GROUND_C : y_down;
                default: ;
            endcase
            if (obst_x_q < speed_ext) begin
                obst_x_d = RESPAWN_X;
                if (score_q != '1) begin
                    score_d = score_q + 1'b1;
                end
                if (clr_inc == CLR_LIMIT) begin
                    clr_d = '0;
                    if (speed_q < SPEED_MAX) begin
                        speed_d = speed_q + 1'b1;
                    end
                end else begin
                    clr_d = clr_inc;
                end
            end else begin
                obst_x_d = obst_x_q - speed_ext;
            end
        end
    end

    // Game-over flag and jump request latch; both only live in rungame.
    always_comb begin
        go_d = 1'b0;
        if (st_run) begin
            go_d = go_q | collision;
        end else if (st_over) begin
            go_d = go_q;
        end
        jump_req_d = 1'b0;
        if (st_run) begin
            jump_req_d = frameTick ? jump_rise : (jump_req_q | jump_rise);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_y_q <= GROUND_C;
            obst_x_q   <= RESPAWN_X;
            speed_q    <= SPEED_INIT;
            clr_q      <= '0;
            score_q    <= '0;
            go_q       <= 1'b0;
            jump_req_q <= 1'b0;
        end else begin
            player_y_q <= player_y_d;
            obst_x_q   <= obst_x_d;
            speed_q    <= speed_d;
            clr_q      <= clr_d;
            score_q    <= score_d;
            go_q       <= go_d;
            jump_req_q <= jump_req_d;
        end
    end

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hi_score_q;
    logic               go_set;

    assign go_set = st_run & ~go_q & collision;

    // Keep the best score seen at any game over; the menu does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_score_q <= '0;
        end else if (go_set && (score_q > hi_score_q)) begin
            hi_score_q <= score_q;
        end
    end

    assign hiScore = hi_score_q;
`endif

    assign GO        = go_q;
    assign score     = score_q;
    assign playerY   = player_y_q;
    assign obstacleX = obst_x_q;

endmodule

// File: tb/tb_game_engine.sv
// Directed bench for game_engine: frame-by-frame obstacle motion, jump
// profile, collision timing, speed ramp, control-state handling and reset.
module tb_game_engine;
    import game_pkg::*;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic [2:0] gameState  = GS_IDLE;
    logic       frameTick  = 1'b0;
    logic       jumpButton = 1'b0;
    logic       GO;
    logic [7:0] score;
    logic [9:0] playerY;
    logic [9:0] obstacleX;
`ifdef HISCORE_EN
    logic [7:0] hiScore;
`endif

    int checks = 0;
    int errors = 0;

    // Expected obstacle/score/speed state for scripted games.
    int exp_x     = 639;
    int exp_speed = 4;
    int exp_clr   = 0;
    int exp_score = 0;

    game_engine dut (
        .clk        (clk),
        .reset      (reset),
        .gameState  (gameState),
        .frameTick  (frameTick),
        .jumpButton (jumpButton),
        .GO         (GO),
        .score      (score),
        .playerY    (playerY),
        .obstacleX  (obstacleX)
`ifdef HISCORE_EN
        ,
        .hiScore    (hiScore)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // One frame tick, plus one extra clock so GO has registered.
    task automatic do_tick();
        @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        @(negedge clk);
    endtask

    // Press and release the jump button between frame ticks.
    task automatic press_button();
        @(negedge clk);
        jumpButton = 1'b1;
        repeat (3) @(negedge clk);
        jumpButton = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Pass through the menu into a fresh rungame.
    task automatic start_game();
        @(negedge clk);
        frameTick = 1'b0;
        gameState = GS_MENU;
        repeat (2) @(negedge clk);
        gameState = GS_RUN;
        exp_x     = 639;
        exp_speed = 4;
        exp_clr   = 0;
        exp_score = 0;
    endtask

    // Expected obstacle motion for one frame tick.
    task automatic model_step(output bit wrapped);
        wrapped = 1'b0;
        if (exp_x < exp_speed) begin
            exp_x   = 639;
            wrapped = 1'b1;
            if (exp_score < 255) exp_score++;
            exp_clr++;
            if (exp_clr == 5) begin
                exp_clr = 0;
                if (exp_speed < 12) exp_speed++;
            end
        end else begin
            exp_x = exp_x - exp_speed;
        end
    endtask

    // Play with a scripted jump each pass until 'clears' wraps; optionally then crash.
    task automatic run_game(input int clears, input bit crash);
        int  done;
        int  guard;
        bit  jumped;
        bit  wrapped;
        bit  hit;
        done   = 0;
        guard  = 0;
        jumped = 1'b0;
        while (done < clears && guard < 20000) begin
            if (!jumped && exp_x > 111 + 5 * exp_speed && exp_x <= 111 + 6 * exp_speed) begin
                press_button();
                jumped = 1'b1;
            end
            do_tick();
            guard++;
            model_step(wrapped);
            if (wrapped) begin
                done++;
                jumped = 1'b0;
            end
            checks++;
            if (obstacleX !== 10'(exp_x)) begin
                errors++;
                $display("FAIL run_x: got %0d expected %0d", obstacleX, exp_x);
            end
            checks++;
            if (score !== 8'(exp_score)) begin
                errors++;
                $display("FAIL run_score: got %0d expected %0d", score, exp_score);
            end
            checks++;
            if (GO !== 1'b0) begin
                errors++;
                $display("FAIL run_go: got %0b expected 0 at x %0d", GO, exp_x);
                break;
            end
        end
        checks++;
        if (done < clears) begin
            errors++;
            $display("FAIL run_clears: got %0d expected %0d", done, clears);
        end
        if (crash) begin
            hit   = 1'b0;
            guard = 0;
            while (!hit && guard < 400) begin
                do_tick();
                guard++;
                model_step(wrapped);
                hit = (exp_x >= 80 && exp_x <= 111);
                checks++;
                if (obstacleX !== 10'(exp_x)) begin
                    errors++;
                    $display("FAIL crash_x: got %0d expected %0d", obstacleX, exp_x);
                end
                checks++;
                if (GO !== hit) begin
                    errors++;
                    $display("FAIL crash_go: got %0b expected %0b at x %0d", GO, hit, exp_x);
                end
            end
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL crash_timeout: got no collision expected one");
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL reset_go: got %0b expected 0", GO); end
        checks++;
        if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL reset_y: got %0d expected 400", playerY); end
        checks++;
        if (obstacleX !== 10'd639) begin errors++; $display("FAIL reset_x: got %0d expected 639", obstacleX); end
        reset = 1'b0;
        gameState = GS_IDLE;
        do_tick();
        checks++;
        if (obstacleX !== 10'd639) begin errors++; $display("FAIL idle_frozen_x: got %0d expected 639", obstacleX); end
    endtask

    task automatic test_no_jump_collision();
        start_game();
        for (int t = 1; t <= 131; t++) begin
            do_tick();
            checks++;
            if (obstacleX !== 10'(639 - 4 * t)) begin
                errors++;
                $display("FAIL nj_x: got %0d expected %0d tick %0d", obstacleX, 639 - 4 * t, t);
            end
            checks++;
            if (GO !== 1'b0) begin errors++; $display("FAIL nj_go_early: got %0b expected 0 tick %0d", GO, t); end
        end
        @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        checks++;
        if (obstacleX !== 10'd111) begin errors++; $display("FAIL nj_x132: got %0d expected 111", obstacleX); end
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL nj_go_latency: got %0b expected 0", GO); end
        @(negedge clk);
        checks++;
        if (GO !== 1'b1) begin errors++; $display("FAIL nj_go_set: got %0b expected 1", GO); end
        repeat (3) do_tick();
        checks++;
        if (obstacleX !== 10'd111) begin errors++; $display("FAIL nj_frozen_x: got %0d expected 111", obstacleX); end
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL nj_frozen_y: got %0d expected 400", playerY); end
        checks++;
        if (score !== 8'd0) begin errors++; $display("FAIL nj_score: got %0d expected 0", score); end
        checks++;
        if (GO !== 1'b1) begin errors++; $display("FAIL nj_go_hold: got %0b expected 1", GO); end
    endtask

    task automatic test_jump_clear();
        int ey;
        int ex;
        start_game();
        for (int t = 1; t <= 124; t++) begin
            do_tick();
            checks++;
            if (obstacleX !== 10'(639 - 4 * t)) begin
                errors++;
                $display("FAIL jc_x: got %0d expected %0d tick %0d", obstacleX, 639 - 4 * t, t);
            end
        end
        press_button();
        for (int t = 125; t <= 160; t++) begin
            do_tick();
            if (t <= 125)      ey = 400;
            else if (t <= 137) ey = 400 - 8 * (t - 125);
            else               ey = 304 + 8 * (t - 137);
            if (ey > 400) ey = 400;
            ex = (t == 160) ? 639 : 639 - 4 * t;
            checks++;
            if (playerY !== 10'(ey)) begin
                errors++;
                $display("FAIL jc_y: got %0d expected %0d tick %0d", playerY, ey, t);
            end
            checks++;
            if (obstacleX !== 10'(ex)) begin
                errors++;
                $display("FAIL jc_x2: got %0d expected %0d tick %0d", obstacleX, ex, t);
            end
            checks++;
            if (GO !== 1'b0) begin errors++; $display("FAIL jc_go: got %0b expected 0 tick %0d", GO, t); end
        end
        checks++;
        if (score !== 8'd1) begin errors++; $display("FAIL jc_score: got %0d expected 1", score); end
    endtask

    task automatic test_button_edges();
        int ey;
        start_game();
        repeat (2) do_tick();
        press_button();
        do_tick();
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL be_launch_y: got %0d expected 400", playerY); end
        for (int t = 4; t <= 30; t++) begin
            if (t == 5 || t == 6) press_button();
            do_tick();
            if (t <= 15) ey = 400 - 8 * (t - 3);
            else         ey = 304 + 8 * (t - 15);
            if (ey > 400) ey = 400;
            checks++;
            if (playerY !== 10'(ey)) begin
                errors++;
                $display("FAIL be_y: got %0d expected %0d tick %0d", playerY, ey, t);
            end
        end
        checks++;
        if (obstacleX !== 10'd519) begin errors++; $display("FAIL be_x: got %0d expected 519", obstacleX); end
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL be_go: got %0b expected 0", GO); end
    endtask

    task automatic test_speed_up();
        start_game();
        run_game(5, 1'b0);
        do_tick();
        checks++;
        if (obstacleX !== 10'd634) begin errors++; $display("FAIL su_step5a: got %0d expected 634", obstacleX); end
        do_tick();
        checks++;
        if (obstacleX !== 10'd629) begin errors++; $display("FAIL su_step5b: got %0d expected 629", obstacleX); end
        exp_x = 629;
        run_game(40, 1'b0);
        do_tick();
        checks++;
        if (obstacleX !== 10'd627) begin errors++; $display("FAIL su_cap_a: got %0d expected 627", obstacleX); end
        do_tick();
        checks++;
        if (obstacleX !== 10'd615) begin errors++; $display("FAIL su_cap_b: got %0d expected 615", obstacleX); end
        checks++;
        if (score !== 8'd45) begin errors++; $display("FAIL su_score: got %0d expected 45", score); end
    endtask

    task automatic test_state_flow();
        start_game();
        run_game(1, 1'b1);
        checks++;
        if (obstacleX !== 10'd111) begin errors++; $display("FAIL sf_crash_x: got %0d expected 111", obstacleX); end
        checks++;
        if (score !== 8'd1) begin errors++; $display("FAIL sf_crash_score: got %0d expected 1", score); end
        @(negedge clk);
        gameState = GS_OVER;
        do_tick();
        checks++;
        if (GO !== 1'b1) begin errors++; $display("FAIL sf_over_go: got %0b expected 1", GO); end
        checks++;
        if (obstacleX !== 10'd111) begin errors++; $display("FAIL sf_over_x: got %0d expected 111", obstacleX); end
        @(negedge clk);
        gameState = GS_IDLE;
        @(negedge clk);
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL sf_idle_go: got %0b expected 0", GO); end
        do_tick();
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL sf_idle_go_hold: got %0b expected 0", GO); end
        checks++;
        if (obstacleX !== 10'd111) begin errors++; $display("FAIL sf_idle_x: got %0d expected 111", obstacleX); end
        checks++;
        if (score !== 8'd1) begin errors++; $display("FAIL sf_idle_score: got %0d expected 1", score); end
        gameState = GS_MENU;
        repeat (2) @(negedge clk);
        checks++;
        if (score !== 8'd0) begin errors++; $display("FAIL sf_menu_score: got %0d expected 0", score); end
        checks++;
        if (obstacleX !== 10'd639) begin errors++; $display("FAIL sf_menu_x: got %0d expected 639", obstacleX); end
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL sf_menu_y: got %0d expected 400", playerY); end
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL sf_menu_go: got %0b expected 0", GO); end
        // frame tick on the same edge as menu -> rungame
        gameState = GS_RUN;
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        checks++;
        if (obstacleX !== 10'd635) begin errors++; $display("FAIL sf_tick_enter_run: got %0d expected 635", obstacleX); end
        // frame tick on the same edge as rungame -> gameover
        gameState = GS_OVER;
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        checks++;
        if (obstacleX !== 10'd635) begin errors++; $display("FAIL sf_tick_enter_over: got %0d expected 635", obstacleX); end
    endtask

    task automatic test_reset_midrun();
        start_game();
        run_game(1, 1'b0);
        press_button();
        repeat (2) do_tick();
        checks++;
        if (playerY !== 10'd392) begin errors++; $display("FAIL rm_pre_y: got %0d expected 392", playerY); end
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (obstacleX !== 10'd639) begin errors++; $display("FAIL rm_x: got %0d expected 639", obstacleX); end
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL rm_y: got %0d expected 400", playerY); end
        checks++;
        if (score !== 8'd0) begin errors++; $display("FAIL rm_score: got %0d expected 0", score); end
        checks++;
        if (GO !== 1'b0) begin errors++; $display("FAIL rm_go: got %0b expected 0", GO); end
        #1;
        reset = 1'b0;
        do_tick();
        checks++;
        if (obstacleX !== 10'd635) begin errors++; $display("FAIL rm_after_x: got %0d expected 635", obstacleX); end
        checks++;
        if (playerY !== 10'd400) begin errors++; $display("FAIL rm_after_y: got %0d expected 400", playerY); end
    endtask

`ifdef HISCORE_EN
    task automatic test_hiscore();
        start_game();
        run_game(3, 1'b1);
        checks++;
        if (hiScore !== 8'd3) begin errors++; $display("FAIL hs_game1: got %0d expected 3", hiScore); end
        start_game();
        @(negedge clk);
        checks++;
        if (hiScore !== 8'd3) begin errors++; $display("FAIL hs_menu_keep: got %0d expected 3", hiScore); end
        run_game(1, 1'b1);
        checks++;
        if (score !== 8'd1) begin errors++; $display("FAIL hs_game2_score: got %0d expected 1", score); end
        checks++;
        if (hiScore !== 8'd3) begin errors++; $display("FAIL hs_game2: got %0d expected 3", hiScore); end
    endtask
`endif

    initial begin
        test_reset();
        test_no_jump_collision();
        test_jump_clear();
        test_button_edges();
        test_speed_up();
        test_state_flow();
        test_reset_midrun();
`ifdef HISCORE_EN
        test_hiscore();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
